// File: rtl/raster_scheduler.sv
// Frame sequencer between projection and rasterizer: clear, dispatch, drain, done.
// Triangles are buffered in a small FIFO and issued one at a time when the rasterizer is idle.
module raster_scheduler #(
    parameter int XWIDTH     = 16,
    parameter int YWIDTH     = 16,
    parameter int ZWIDTH     = 16,
    parameter int N          = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   frame_start_in,
    input  logic                   frame_end_in,
    input  logic                   tri_valid_in,
    output logic                   tri_ready_out,
    input  logic [N*XWIDTH-1:0]    x_in,
    input  logic [N*YWIDTH-1:0]    y_in,
    input  logic [N*ZWIDTH-1:0]    z_in,
    output logic                   clear_start_out,
    input  logic                   clear_done_in,
    output logic                   rast_valid_out,
    input  logic                   rast_ready_in,
    output logic [N*XWIDTH-1:0]    rast_x_out,
    output logic [N*YWIDTH-1:0]    rast_y_out,
    output logic [N*ZWIDTH-1:0]    rast_z_out,
    output logic                   frame_done_out,
    output logic                   busy_out,
    output logic [CNT_WIDTH-1:0]   tri_issued_out,
    output logic [CNT_WIDTH-1:0]   tri_done_out
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = N * (XWIDTH + YWIDTH + ZWIDTH);

    typedef enum logic [2:0] {
        F_IDLE  = 3'd0,
        F_CLEAR = 3'd1,
        F_RUN   = 3'd2,
        F_DRAIN = 3'd3,
        F_DONE  = 3'd4
    } state_t;

    state_t state, state_next;

    logic [TW-1:0] mem [FIFO_DEPTH];
    logic [TW-1:0] head;
    logic [AW:0]   wr_ptr, rd_ptr, count;
    logic          full, empty, push, issue, complete, rast_busy;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr[AW-1:0]];
    assign push  = tri_valid_in && tri_ready_out;
    // Ready seen after the strobe cycle means the rasterizer has finished (or rejected) the triangle.
    assign complete = rast_busy && !rast_valid_out && rast_ready_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= F_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            F_IDLE:  if (frame_start_in) state_next = F_CLEAR;
            F_CLEAR: if (clear_done_in)  state_next = F_RUN;
            F_RUN:   if (frame_end_in)   state_next = F_DRAIN;
            F_DRAIN: if (empty && !rast_busy) state_next = F_DONE;
            F_DONE:  state_next = F_IDLE;
            default: state_next = F_IDLE;
        endcase
    end

    always_comb begin
        tri_ready_out  = 1'b0;
        frame_done_out = 1'b0;
        busy_out       = (state != F_IDLE);
        issue          = 1'b0;
        case (state)
            F_CLEAR: tri_ready_out = !full;
            F_RUN: begin
                tri_ready_out = !full;
                issue         = !empty && rast_ready_in && !rast_busy;
            end
            F_DRAIN: issue = !empty && rast_ready_in && !rast_busy;
            F_DONE:  frame_done_out = 1'b1;
            default: ;
        endcase
    end

    // Pointers carry one extra bit so full and empty are distinguishable.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + (AW+1)'(1);
            if (issue) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {x_in, y_in, z_in};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            clear_start_out <= 1'b0;
            rast_valid_out  <= 1'b0;
            rast_busy       <= 1'b0;
            rast_x_out      <= '0;
            rast_y_out      <= '0;
            rast_z_out      <= '0;
            tri_issued_out  <= '0;
            tri_done_out    <= '0;
        end else begin
            clear_start_out <= (state == F_IDLE) && frame_start_in;
            rast_valid_out  <= issue;
            if (issue) begin
                {rast_x_out, rast_y_out, rast_z_out} <= head;
                rast_busy      <= 1'b1;
                tri_issued_out <= tri_issued_out + CNT_WIDTH'(1);
            end else if (complete) begin
                rast_busy    <= 1'b0;
                tri_done_out <= tri_done_out + CNT_WIDTH'(1);
            end
            if ((state == F_IDLE) && frame_start_in) begin
                tri_issued_out <= '0;
                tri_done_out   <= '0;
            end
        end
    end

endmodule
